// File: rtl/dla_noc_packetizer_pkg.sv
// Shared NoC definitions: flit geometry, destination field widths and flit labels.
package dla_noc_packetizer_pkg;

  localparam int FLIT_DATA_SIZE   = 32;
  localparam int FLIT_LABEL_SIZE  = 2;
  localparam int FLIT_TOTAL_SIZE  = FLIT_DATA_SIZE + FLIT_LABEL_SIZE;
  localparam int DEST_ADDR_SIZE_X = 4;
  localparam int DEST_ADDR_SIZE_Y = 4;
  localparam int DEST_ADDR_SIZE_L = 3;
  localparam int HEAD_PL_SIZE     = DEST_ADDR_SIZE_X + DEST_ADDR_SIZE_Y + 2;

  typedef enum logic [FLIT_LABEL_SIZE-1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

endpackage

// File: rtl/dla_noc_packetizer.sv
// Turns packet requests and a payload word stream into NoC flits written to the
// DLA-to-router async FIFO. Grant messages are a single HEADTAIL flit.
module dla_noc_packetizer
  import dla_noc_packetizer_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic                        clk_dla,
  input  logic                        rst_dla,
  input  logic                        req_vld,
  output logic                        req_rdy,
  input  logic                        req_type,
  input  logic [DEST_ADDR_SIZE_X-1:0] req_dest_x,
  input  logic [DEST_ADDR_SIZE_Y-1:0] req_dest_y,
  input  logic [DEST_ADDR_SIZE_L-1:0] req_dest_l,
  input  logic [LEN_W-1:0]            req_len,
  input  logic [HEAD_PL_SIZE-1:0]     req_gnt_pl,
  input  logic                        dat_vld,
  output logic                        dat_rdy,
  input  logic [FLIT_DATA_SIZE-1:0]   dat_data,
  input  logic                        wbuf_full,
  input  logic                        wbuf_afull,
  output logic                        wbuf_wen,
  output logic [FLIT_TOTAL_SIZE-1:0]  wbuf_wdata,
  output logic                        busy,
  output logic                        err_len0
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [LEN_W-1:0]            cnt_q, cnt_d;
  logic                        type_q, type_d;
  logic [DEST_ADDR_SIZE_X-1:0] x_q, x_d;
  logic [DEST_ADDR_SIZE_Y-1:0] y_q, y_d;
  logic [DEST_ADDR_SIZE_L-1:0] l_q, l_d;
  logic [HEAD_PL_SIZE-1:0]     gnt_q, gnt_d;
  logic                        err_q, err_d;
  logic                        idle_rdy;
  flit_label_t                 lbl;
  logic [FLIT_DATA_SIZE-1:0]   flit_data;

  // Almost-full is status only; the packetizer stalls on full alone.
  logic unused_afull;
  assign unused_afull = wbuf_afull;

  function automatic logic [FLIT_DATA_SIZE-1:0] fmt_head(
    input logic [DEST_ADDR_SIZE_X-1:0] x,
    input logic [DEST_ADDR_SIZE_Y-1:0] y,
    input logic [DEST_ADDR_SIZE_L-1:0] l,
    input logic [HEAD_PL_SIZE-1:0]     pl
  );
    logic [FLIT_DATA_SIZE-1:0] h;
    h = '0;
    h[0 +: DEST_ADDR_SIZE_L] = l;
    h[DEST_ADDR_SIZE_L +: DEST_ADDR_SIZE_Y] = y;
    h[DEST_ADDR_SIZE_L+DEST_ADDR_SIZE_Y +: DEST_ADDR_SIZE_X] = x;
    h[DEST_ADDR_SIZE_L+DEST_ADDR_SIZE_Y+DEST_ADDR_SIZE_X +: HEAD_PL_SIZE] = pl;
    return h;
  endfunction

  always_ff @(posedge clk_dla or posedge rst_dla) begin
    if (rst_dla) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      type_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      l_q     <= '0;
      gnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      type_q  <= type_d;
      x_q     <= x_d;
      y_q     <= y_d;
      l_q     <= l_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    type_d    = type_q;
    x_d       = x_q;
    y_d       = y_q;
    l_d       = l_q;
    gnt_d     = gnt_q;
    err_d     = 1'b0;
    idle_rdy  = 1'b0;
    dat_rdy   = 1'b0;
    busy      = 1'b0;
    wbuf_wen  = 1'b0;
    lbl       = HEAD;
    flit_data = '0;
    unique case (state_q)
      ST_IDLE: begin
        idle_rdy = 1'b1;
        if (req_vld) begin
          type_d = req_type;
          x_d    = req_dest_x;
          y_d    = req_dest_y;
          l_d    = req_dest_l;
          gnt_d  = req_gnt_pl;
          cnt_d  = req_len;
          // Empty data packets are swallowed and flagged rather than sent.
          if (!req_type && (req_len == '0)) err_d = 1'b1;
          else                               state_d = ST_HEAD;
        end
      end
      ST_HEAD: begin
        busy      = 1'b1;
        lbl       = type_q ? HEADTAIL : HEAD;
        flit_data = fmt_head(x_q, y_q, l_q, type_q ? gnt_q : '0);
        wbuf_wen  = !wbuf_full;
        if (!wbuf_full) state_d = type_q ? ST_IDLE : ST_BODY;
      end
      ST_BODY: begin
        busy      = 1'b1;
        dat_rdy   = !wbuf_full;
        lbl       = (cnt_q == LEN_W'(1)) ? TAIL : BODY;
        flit_data = dat_data;
        if (dat_vld && !wbuf_full) begin
          wbuf_wen = 1'b1;
          if (cnt_q != '0) cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q <= LEN_W'(1)) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wbuf_wdata = {lbl, flit_data};
  assign req_rdy    = idle_rdy & ~rst_dla;
  assign err_len0   = err_q;

endmodule

// File: tb/tb_dla_noc_packetizer.sv
// Directed bench for dla_noc_packetizer with hand-computed flit values.
module tb_dla_noc_packetizer;
  import dla_noc_packetizer_pkg::*;

  logic        clk_dla = 1'b0;
  logic        rst_dla;
  logic        req_vld, req_type;
  logic [3:0]  req_dest_x, req_dest_y;
  logic [2:0]  req_dest_l;
  logic [7:0]  req_len;
  logic [9:0]  req_gnt_pl;
  logic        dat_vld;
  logic [31:0] dat_data;
  logic        wbuf_full, wbuf_afull;
  logic        req_rdy, dat_rdy, wbuf_wen, busy, err_len0;
  logic [33:0] wbuf_wdata;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_dla = ~clk_dla;

  dla_noc_packetizer #(.LEN_W(8)) dut (
    .clk_dla(clk_dla), .rst_dla(rst_dla),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_type(req_type),
    .req_dest_x(req_dest_x), .req_dest_y(req_dest_y), .req_dest_l(req_dest_l),
    .req_len(req_len), .req_gnt_pl(req_gnt_pl),
    .dat_vld(dat_vld), .dat_rdy(dat_rdy), .dat_data(dat_data),
    .wbuf_full(wbuf_full), .wbuf_afull(wbuf_afull),
    .wbuf_wen(wbuf_wen), .wbuf_wdata(wbuf_wdata),
    .busy(busy), .err_len0(err_len0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_dla);
    #1;
  endtask

  task automatic set_req(input logic t, input logic [3:0] x, input logic [3:0] y,
                         input logic [2:0] l, input logic [7:0] len, input logic [9:0] pl);
    req_vld = 1'b1; req_type = t; req_dest_x = x; req_dest_y = y;
    req_dest_l = l; req_len = len; req_gnt_pl = pl;
  endtask

  // Writes a flit this cycle with the given value
  task automatic chk_wr(input string tag, input logic [33:0] exp);
    chk({tag, "_wen"}, 64'(wbuf_wen), 64'd1);
    chk({tag, "_wdata"}, 64'(wbuf_wdata), 64'(exp));
  endtask

  initial begin
    rst_dla = 1'b1; req_vld = 0; req_type = 0; req_dest_x = 0; req_dest_y = 0;
    req_dest_l = 0; req_len = 0; req_gnt_pl = 0; dat_vld = 0; dat_data = 0;
    wbuf_full = 0; wbuf_afull = 0;
    #2;
    chk("rst_wen", 64'(wbuf_wen), 64'd0);
    chk("rst_datrdy", 64'(dat_rdy), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_reqrdy", 64'(req_rdy), 64'd0);
    chk("rst_err", 64'(err_len0), 64'd0);
    tick(); tick();
    rst_dla = 1'b0;
    #1;
    chk("rel_reqrdy", 64'(req_rdy), 64'd1);

    // Data packet x=3 y=2 l=5 len=3
    tick();
    set_req(1'b0, 4'd3, 4'd2, 3'd5, 8'd3, 10'd0);
    #1 chk("d3_acc_rdy", 64'(req_rdy), 64'd1);
    tick();
    req_vld = 0; dat_vld = 1; dat_data = 32'hA1;
    #1 chk_wr("d3_head", {2'd0, 32'h0000_0195});
    chk("d3_head_busy", 64'(busy), 64'd1);
    chk("d3_head_reqrdy", 64'(req_rdy), 64'd0);
    chk("d3_head_datrdy", 64'(dat_rdy), 64'd0);
    tick();
    #1 chk_wr("d3_b1", {2'd1, 32'hA1});
    chk("d3_b1_datrdy", 64'(dat_rdy), 64'd1);
    tick();
    dat_data = 32'hA2;
    #1 chk_wr("d3_b2", {2'd1, 32'hA2});
    tick();
    dat_data = 32'hA3;
    #1 chk_wr("d3_tail", {2'd2, 32'hA3});
    tick();
    dat_vld = 0;
    #1 chk("d3_end_reqrdy", 64'(req_rdy), 64'd1);
    chk("d3_end_busy", 64'(busy), 64'd0);
    chk("d3_end_wen", 64'(wbuf_wen), 64'd0);

    // Grant x=1 y=0 l=0 pl=0b0000011001 (len=0 must not flag an error)
    set_req(1'b1, 4'd1, 4'd0, 3'd0, 8'd0, 10'b0000011001);
    tick();
    req_vld = 0;
    #1 chk_wr("gnt_ht", {2'd3, 32'h0000_C880});
    chk("gnt_busy", 64'(busy), 64'd1);
    tick();
    chk("gnt_busy_after", 64'(busy), 64'd0);
    chk("gnt_wen_after", 64'(wbuf_wen), 64'd0);
    chk("gnt_reqrdy_after", 64'(req_rdy), 64'd1);
    chk("gnt_no_err", 64'(err_len0), 64'd0);

    // len=2 with FIFO full for 3 cycles after HEAD; afull must not stall
    set_req(1'b0, 4'd0, 4'd0, 3'd1, 8'd2, 10'd0);
    tick();
    req_vld = 0;
    #1 chk_wr("st_head", {2'd0, 32'h1});
    tick();
    wbuf_full = 1; dat_vld = 1; dat_data = 32'hB1;
    #1 chk("st_full1_wen", 64'(wbuf_wen), 64'd0);
    chk("st_full1_datrdy", 64'(dat_rdy), 64'd0);
    chk("st_full1_wdata", 64'(wbuf_wdata), 64'({2'd1, 32'hB1}));
    tick();
    chk("st_full2_wen", 64'(wbuf_wen), 64'd0);
    chk("st_full2_wdata", 64'(wbuf_wdata), 64'({2'd1, 32'hB1}));
    tick();
    chk("st_full3_wen", 64'(wbuf_wen), 64'd0);
    chk("st_full3_datrdy", 64'(dat_rdy), 64'd0);
    tick();
    wbuf_full = 0; wbuf_afull = 1;
    #1 chk_wr("st_b1", {2'd1, 32'hB1});
    tick();
    dat_data = 32'hB2;
    #1 chk_wr("st_tail", {2'd2, 32'hB2});
    tick();
    dat_vld = 0; wbuf_afull = 0;
    #1 chk("st_end_wen", 64'(wbuf_wen), 64'd0);
    chk("st_end_reqrdy", 64'(req_rdy), 64'd1);

    // len=0 data packet
    set_req(1'b0, 4'd5, 4'd5, 3'd5, 8'd0, 10'd0);
    tick();
    req_vld = 0;
    #1 chk("l0_wen", 64'(wbuf_wen), 64'd0);
    chk("l0_err", 64'(err_len0), 64'd1);
    chk("l0_busy", 64'(busy), 64'd0);
    chk("l0_reqrdy", 64'(req_rdy), 64'd1);
    tick();
    chk("l0_err_clear", 64'(err_len0), 64'd0);

    // Back to back: len=1 then grant x=0 y=1 l=0 pl=0x3FF held valid while busy
    set_req(1'b0, 4'd0, 4'd0, 3'd2, 8'd1, 10'd0);
    tick();
    set_req(1'b1, 4'd0, 4'd1, 3'd0, 8'd0, 10'h3FF);
    #1 chk_wr("bb_head", {2'd0, 32'h2});
    chk("bb_head_reqrdy", 64'(req_rdy), 64'd0);
    tick();
    dat_vld = 1; dat_data = 32'hE1;
    #1 chk_wr("bb_tail", {2'd2, 32'hE1});
    tick();
    dat_vld = 0;
    #1 chk("bb_idle_wen", 64'(wbuf_wen), 64'd0);
    chk("bb_idle_reqrdy", 64'(req_rdy), 64'd1);
    tick();
    req_vld = 0;
    #1 chk_wr("bb_ht", {2'd3, 32'h001F_F808});
    tick();
    chk("bb_end_wen", 64'(wbuf_wen), 64'd0);

    // Reset after second BODY of a len=5 packet
    set_req(1'b0, 4'd0, 4'd0, 3'd0, 8'd5, 10'd0);
    tick();
    req_vld = 0;
    #1 chk_wr("rm_head", {2'd0, 32'h0});
    tick();
    dat_vld = 1; dat_data = 32'hC1;
    #1 chk_wr("rm_b1", {2'd1, 32'hC1});
    tick();
    dat_data = 32'hC2;
    #1 chk_wr("rm_b2", {2'd1, 32'hC2});
    tick();
    dat_data = 32'hC3;
    rst_dla = 1'b1;
    #1 chk("rm_rst_wen", 64'(wbuf_wen), 64'd0);
    chk("rm_rst_busy", 64'(busy), 64'd0);
    chk("rm_rst_datrdy", 64'(dat_rdy), 64'd0);
    chk("rm_rst_reqrdy", 64'(req_rdy), 64'd0);
    tick();
    rst_dla = 1'b0; dat_vld = 0;
    #1 chk("rm_rel_reqrdy", 64'(req_rdy), 64'd1);
    chk("rm_rel_busy", 64'(busy), 64'd0);
    set_req(1'b0, 4'd2, 4'd1, 3'd3, 8'd1, 10'd0);
    tick();
    req_vld = 0;
    #1 chk_wr("rm_new_head", {2'd0, 32'h0000_010B});
    tick();
    dat_vld = 1; dat_data = 32'hD1;
    #1 chk_wr("rm_new_tail", {2'd2, 32'hD1});
    tick();
    dat_vld = 0;
    #1 chk("rm_new_end_reqrdy", 64'(req_rdy), 64'd1);
    chk("rm_new_end_wen", 64'(wbuf_wen), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
